// File: rtl/seg_scan_ctrl_if.sv
// Write port and display drive bundle for the seven-segment scan controller.
// The slave side is the controller; the master side is the writer/board.
interface seg_scan_ctrl_if;
    logic       wr_valid;
    logic       wr_ready;
    logic [1:0] wr_addr;
    logic [3:0] wr_data;
    logic       wr_dp;
    logic       wr_en;
    logic       commit;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       frame_tick;

    modport master (
        output wr_valid, wr_addr, wr_data, wr_dp, wr_en, commit,
        input  wr_ready, an, seg, dp, frame_tick
    );

    modport slave (
        input  wr_valid, wr_addr, wr_data, wr_dp, wr_en, commit,
        output wr_ready, an, seg, dp, frame_tick
    );
endinterface

// File: rtl/seg_scan_ctrl.sv
// Four-digit seven-segment scan controller. Digits are written into a shadow
// bank and copied to the active bank in one step at the frame boundary after a
// commit, so the scan never shows a half-updated value.
module seg_scan_ctrl #(
    parameter int DWELL_CYCLES = 100_000,
    parameter int BLANK_CYCLES = 1_000
) (
    input  logic           clk,
    input  logic           rst_n,
    seg_scan_ctrl_if.slave bus
);

    localparam int CNT_MAX = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
    localparam int CW      = $clog2(CNT_MAX + 1);
    localparam logic [CW-1:0] DWELL_LAST = CW'(DWELL_CYCLES - 1);
    localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);

    typedef enum logic {ST_BLANK, ST_DRIVE} state_t;

    typedef struct packed {
        logic [3:0] data;
        logic       dp;
        logic       en;
    } digit_t;

    // Hex nibble to active-low {g,f,e,d,c,b,a}
    function automatic logic [6:0] hex7(input logic [3:0] h);
        case (h)
            4'h0: hex7 = 7'b1000000;
            4'h1: hex7 = 7'b1111001;
            4'h2: hex7 = 7'b0100100;
            4'h3: hex7 = 7'b0110000;
            4'h4: hex7 = 7'b0011001;
            4'h5: hex7 = 7'b0010010;
            4'h6: hex7 = 7'b0000010;
            4'h7: hex7 = 7'b1111000;
            4'h8: hex7 = 7'b0000000;
            4'h9: hex7 = 7'b0010000;
            4'hA: hex7 = 7'b0001000;
            4'hB: hex7 = 7'b0000011;
            4'hC: hex7 = 7'b1000110;
            4'hD: hex7 = 7'b0100001;
            4'hE: hex7 = 7'b0000110;
            default: hex7 = 7'b0001110;
        endcase
    endfunction

    // Digit 0 is the leftmost position, driven by an[3]
    function automatic logic [3:0] an_pat(input logic [1:0] i);
        case (i)
            2'd0: an_pat = 4'b0111;
            2'd1: an_pat = 4'b1011;
            2'd2: an_pat = 4'b1101;
            default: an_pat = 4'b1110;
        endcase
    endfunction

    state_t        state_q;
    logic [1:0]    idx_q;
    logic [CW-1:0] cnt_q;
    logic [3:0]    an_q;
    logic [6:0]    seg_q;
    logic          dp_q;
    logic          tick_q;
    logic          pending_q;
    logic          wr_ready_q;
    digit_t        shadow_q [4];
    digit_t        active_q [4];

    logic          cnt_done_d;
    logic          frame_end_d;
    logic          wr_fire_d;
    logic          pending_d;

    // Phase end detection, frame boundary and commit tracking
    always_comb begin
        cnt_done_d  = (state_q == ST_BLANK) ? (cnt_q == BLANK_LAST) : (cnt_q == DWELL_LAST);
        frame_end_d = (state_q == ST_DRIVE) && cnt_done_d && (idx_q == 2'd3);
        wr_fire_d   = bus.wr_valid && wr_ready_q;
        pending_d   = pending_q;
        if (frame_end_d && pending_q) begin
            pending_d = 1'b0;
        end else if (bus.commit && !pending_q) begin
            pending_d = 1'b1;
        end
    end

    // Shadow writes, atomic bank swap and write-port flow control
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) begin
                shadow_q[i] <= '0;
                active_q[i] <= '0;
            end
            pending_q  <= 1'b0;
            wr_ready_q <= 1'b1;
        end else begin
            if (wr_fire_d) begin
                shadow_q[bus.wr_addr] <= '{data: bus.wr_data, dp: bus.wr_dp, en: bus.wr_en};
            end
            if (frame_end_d && pending_q) begin
                active_q <= shadow_q;
            end
            pending_q  <= pending_d;
            wr_ready_q <= !pending_d;
        end
    end

    // Scan FSM with registered anode/segment outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_BLANK;
            idx_q   <= 2'd0;
            cnt_q   <= '0;
            an_q    <= 4'b1111;
            seg_q   <= 7'b1111111;
            dp_q    <= 1'b1;
            tick_q  <= 1'b0;
        end else begin
            tick_q <= frame_end_d;
            if (!cnt_done_d) begin
                cnt_q <= cnt_q + 1'b1;
            end else begin
                cnt_q <= '0;
                if (state_q == ST_BLANK) begin
                    state_q <= ST_DRIVE;
                    if (active_q[idx_q].en) begin
                        an_q  <= an_pat(idx_q);
                        seg_q <= hex7(active_q[idx_q].data);
                        dp_q  <= !active_q[idx_q].dp;
                    end else begin
                        an_q  <= 4'b1111;
                        seg_q <= 7'b1111111;
                        dp_q  <= 1'b1;
                    end
                end else begin
                    state_q <= ST_BLANK;
                    idx_q   <= idx_q + 2'd1;
                    an_q    <= 4'b1111;
                    seg_q   <= 7'b1111111;
                    dp_q    <= 1'b1;
                end
            end
        end
    end

    assign bus.wr_ready   = wr_ready_q;
    assign bus.an         = an_q;
    assign bus.seg        = seg_q;
    assign bus.dp         = dp_q;
    assign bus.frame_tick = tick_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed bench for seg_scan_ctrl with DWELL_CYCLES=4, BLANK_CYCLES=2
// (24-cycle frame). Inputs are driven and outputs sampled on the falling edge.
module tb_seg_scan_ctrl;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_errors;
    int   n_cyc;

    seg_scan_ctrl_if bus ();

    seg_scan_ctrl #(
        .DWELL_CYCLES(4),
        .BLANK_CYCLES(2)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [3:0] AN_PAT [4] = '{4'b0111, 4'b1011, 4'b1101, 4'b1110};
    logic [6:0] exp_seg [4];
    logic       exp_dp  [4];
    logic       exp_en  [4];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance to the next falling edge that sees frame_tick, bounded
    task automatic wait_tick(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.frame_tick && n < 40);
        check("frame_tick seen", 32'(bus.frame_tick), 32'd1);
    endtask

    // Check one frame from position start (0 = the cycle frame_tick is high)
    task automatic check_frame(input int start);
        for (int p = start; p < 24; p++) begin
            int d;
            int q;
            logic [3:0] ea;
            logic [6:0] es;
            logic       ed;
            d  = p / 6;
            q  = p % 6;
            ea = 4'b1111;
            es = 7'b1111111;
            ed = 1'b1;
            if (q >= 2 && exp_en[d]) begin
                ea = AN_PAT[d];
                es = exp_seg[d];
                ed = !exp_dp[d];
            end
            check($sformatf("an p%0d", p),   32'(bus.an),  32'(ea));
            check($sformatf("seg p%0d", p),  32'(bus.seg), 32'(es));
            check($sformatf("dp p%0d", p),   32'(bus.dp),  32'(ed));
            check($sformatf("tick p%0d", p), 32'(bus.frame_tick), (p == 0) ? 32'd1 : 32'd0);
            @(negedge clk);
        end
    endtask

    task automatic do_write(input logic [1:0] a, input logic [3:0] v,
                            input logic pt, input logic e, input logic cmt);
        int  n;
        logic ok;
        bus.wr_valid = 1'b1;
        bus.wr_addr  = a;
        bus.wr_data  = v;
        bus.wr_dp    = pt;
        bus.wr_en    = e;
        bus.commit   = cmt;
        n  = 0;
        ok = 1'b0;
        while (!ok && n < 40) begin
            ok = bus.wr_ready;
            @(negedge clk);
            bus.commit = 1'b0;
            n++;
        end
        bus.wr_valid = 1'b0;
        check("write accepted", 32'(ok), 32'd1);
    endtask

    task automatic pulse_commit();
        bus.commit = 1'b1;
        @(negedge clk);
        bus.commit = 1'b0;
        check("wr_ready after commit", 32'(bus.wr_ready), 32'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " an"},    32'(bus.an),  32'hF);
        check({tag, " seg"},   32'(bus.seg), 32'h7F);
        check({tag, " dp"},    32'(bus.dp),  32'd1);
        check({tag, " ready"}, 32'(bus.wr_ready), 32'd1);
        check({tag, " tick"},  32'(bus.frame_tick), 32'd0);
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst_n        = 1'b0;
        bus.wr_valid = 1'b0;
        bus.wr_addr  = 2'd0;
        bus.wr_data  = 4'd0;
        bus.wr_dp    = 1'b0;
        bus.wr_en    = 1'b0;
        bus.commit   = 1'b0;
        for (int i = 0; i < 4; i++) begin
            exp_seg[i] = 7'b1111111;
            exp_dp[i]  = 1'b0;
            exp_en[i]  = 1'b0;
        end

        // Reset state and blank frames after release
        @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1'b1;
        wait_tick(n_cyc);
        check("first frame length", 32'(n_cyc), 32'd24);
        check_frame(0);
        check_frame(0);

        // Digits {1,2,3,F}, dp on digit 2, then commit
        do_write(2'd0, 4'h1, 1'b0, 1'b1, 1'b0);
        do_write(2'd1, 4'h2, 1'b0, 1'b1, 1'b0);
        do_write(2'd2, 4'h3, 1'b1, 1'b1, 1'b0);
        do_write(2'd3, 4'hF, 1'b0, 1'b1, 1'b0);
        pulse_commit();
        @(negedge clk);
        check("wr_ready held low", 32'(bus.wr_ready), 32'd0);
        wait_tick(n_cyc);
        check("wr_ready after swap", 32'(bus.wr_ready), 32'd1);
        exp_seg[0] = 7'b1111001; exp_en[0] = 1'b1;
        exp_seg[1] = 7'b0100100; exp_en[1] = 1'b1;
        exp_seg[2] = 7'b0110000; exp_en[2] = 1'b1; exp_dp[2] = 1'b1;
        exp_seg[3] = 7'b0001110; exp_en[3] = 1'b1;
        check_frame(0);

        // Disable digit 1
        do_write(2'd1, 4'h2, 1'b0, 1'b0, 1'b0);
        pulse_commit();
        wait_tick(n_cyc);
        exp_en[1] = 1'b0;
        check_frame(0);

        // Uncommitted write stays invisible for three frames
        do_write(2'd0, 4'h9, 1'b0, 1'b1, 1'b0);
        wait_tick(n_cyc);
        check_frame(0);
        check_frame(0);
        check_frame(0);
        // Write to digit 3 together with commit
        do_write(2'd3, 4'h8, 1'b0, 1'b1, 1'b1);
        check("wr_ready after write+commit", 32'(bus.wr_ready), 32'd0);
        wait_tick(n_cyc);
        exp_seg[0] = 7'b0010000;
        exp_seg[3] = 7'b0000000;
        check_frame(0);

        // Second commit and a write while pending
        pulse_commit();
        bus.commit   = 1'b1;
        bus.wr_valid = 1'b1;
        bus.wr_addr  = 2'd1;
        bus.wr_data  = 4'h7;
        bus.wr_dp    = 1'b0;
        bus.wr_en    = 1'b1;
        @(negedge clk);
        bus.commit = 1'b0;
        for (int k = 0; k < 3; k++) begin
            check("ready low while pending", 32'(bus.wr_ready), 32'd0);
            @(negedge clk);
        end
        wait_tick(n_cyc);
        check("ready at swap", 32'(bus.wr_ready), 32'd1);
        @(negedge clk);
        bus.wr_valid = 1'b0;
        check("second commit ignored", 32'(bus.wr_ready), 32'd1);
        check_frame(1);
        check_frame(0);
        pulse_commit();
        wait_tick(n_cyc);
        exp_seg[1] = 7'b1111000;
        exp_en[1]  = 1'b1;
        check_frame(0);

        // Asynchronous reset during DRIVE(2) with a commit pending
        pulse_commit();
        repeat (14) @(negedge clk);
        check("an in DRIVE(2)", 32'(bus.an), 32'b1101);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("async reset");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        wait_tick(n_cyc);
        check("frame length after reset", 32'(n_cyc), 32'd24);
        for (int i = 0; i < 4; i++) begin
            exp_en[i] = 1'b0;
        end
        check_frame(0);
        check("wr_ready after reset", 32'(bus.wr_ready), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
